// File: rtl/ddr_ca_lane_delay_ctrl.sv
// ddr_ca_lane_delay_ctrl
// Sequences the dynamic output delay lines of a group of DDR command/address
// IOD lanes. Training logic posts per-lane adjust requests over valid/ready.
// The controller pulses MOVE/DIRECTION/LOAD on the selected lane, keeps a
// shadow tap count per lane, enforces the tap range and settle time, and
// returns a one-cycle status response.
//
// Ports:
//   FAB_CLK, ARST_N          clock, async active-low reset
//   REQ_VALID/READY          request handshake
//   REQ_LANE/OP/STEPS        lane, op (00 inc, 01 dec, 10 load, 11 set), steps/target
//   RSP_VALID/STATUS/TAPS    response strobe, status (00 ok, 01 clip, 10 oor, 11 bad lane), taps
//   BUSY                     high whenever not idle
//   DELAY_LINE_*             per-lane IOD delay-line controls / out-of-range flag
//   TAP_COUNT                shadow tap counts, lane i at [i*TAP_W +: TAP_W]
//
// state         | meaning
// --------------+-----------------------------------------------------
// INIT_LOAD     | after reset: one LOAD pulse on all lanes
// INIT_SETTLE   | settle after the initial load
// IDLE          | ready for a request
// DIR           | direction driven on the lane ahead of the first move
// MOVE          | one-cycle move pulse
// SETTLE        | settle after a move; out-of-range sampled on last cycle
// LOAD          | one-cycle load pulse on the lane
// LSETTLE       | settle after a lane load
// RESP          | one-cycle response strobe
module ddr_ca_lane_delay_ctrl #(
  parameter int NUM_LANES     = 8,
  parameter int LANE_W        = 3,
  parameter int TAP_W         = 8,
  parameter int MAX_TAP       = 255,
  parameter int LOAD_TAP      = 1,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                         FAB_CLK,
  input  logic                         ARST_N,
  input  logic                         REQ_VALID,
  output logic                         REQ_READY,
  input  logic [LANE_W-1:0]            REQ_LANE,
  input  logic [1:0]                   REQ_OP,
  input  logic [TAP_W-1:0]             REQ_STEPS,
  output logic                         RSP_VALID,
  output logic [1:0]                   RSP_STATUS,
  output logic [TAP_W-1:0]             RSP_TAPS,
  output logic                         BUSY,
  output logic [NUM_LANES-1:0]         DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]         DELAY_LINE_DIRECTION,
  output logic [NUM_LANES-1:0]         DELAY_LINE_LOAD,
  input  logic [NUM_LANES-1:0]         DELAY_LINE_OUT_OF_RANGE,
  output logic [NUM_LANES*TAP_W-1:0]   TAP_COUNT
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [TAP_W-1:0] MAX_T  = TAP_W'(MAX_TAP);
  localparam logic [TAP_W-1:0] LOAD_T = TAP_W'(LOAD_TAP);
  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_SET  = 2'b11;

  typedef enum logic [3:0] {
    S_INIT_LOAD, S_INIT_SETTLE, S_IDLE, S_DIR, S_MOVE,
    S_SETTLE, S_LOAD, S_LSETTLE, S_RESP
  } state_t;

  state_t state, next_state;

  logic [TAP_W-1:0]     taps [NUM_LANES];
  logic [LANE_W-1:0]    lane_q;
  logic                 dir_q;
  logic [TAP_W-1:0]     steps_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 clip_q, oor_q, bad_q;
  logic                 init_pulse;

  logic [NUM_LANES-1:0] req_oh, lane_oh;
  logic [TAP_W-1:0]     req_tap, sel_tap;
  logic                 lane_ok;
  logic                 acc_dir, acc_clip, acc_at_limit;
  logic [TAP_W-1:0]     acc_steps, target;
  logic [TAP_W-1:0]     step_tap;
  logic                 step_at_limit, oor_hit, settle_done;

  // Lane decode by compare loop so an index beyond NUM_LANES simply matches nothing.
  always_comb begin
    req_oh  = '0;
    lane_oh = '0;
    req_tap = '0;
    sel_tap = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (REQ_LANE == LANE_W'(i)) begin
        req_oh[i] = 1'b1;
        req_tap   = taps[i];
      end
      if (lane_q == LANE_W'(i)) begin
        lane_oh[i] = 1'b1;
        sel_tap    = taps[i];
      end
    end
  end

  assign lane_ok = |req_oh;

  // Set-absolute is converted to an inc/dec of |target - current| steps.
  always_comb begin
    acc_dir   = 1'b1;
    acc_steps = REQ_STEPS;
    acc_clip  = 1'b0;
    target    = REQ_STEPS;
    case (REQ_OP)
      OP_INC: acc_dir = 1'b1;
      OP_DEC: acc_dir = 1'b0;
      OP_SET: begin
        if (REQ_STEPS > MAX_T) begin
          target   = MAX_T;
          acc_clip = 1'b1;
        end
        acc_dir   = (target > req_tap);
        acc_steps = acc_dir ? (target - req_tap) : (req_tap - target);
      end
      default: ;
    endcase
    acc_at_limit = acc_dir ? (req_tap >= MAX_T) : (req_tap == '0);
  end

  assign step_tap      = dir_q ? (sel_tap + 1'b1) : (sel_tap - 1'b1);
  assign step_at_limit = dir_q ? (step_tap >= MAX_T) : (step_tap == '0);
  assign oor_hit       = |(DELAY_LINE_OUT_OF_RANGE & lane_oh);
  assign settle_done   = (cnt_q == '0);

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) state <= S_INIT_LOAD;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      // Wait one cycle so the init LOAD pulse is registered clear of reset.
      S_INIT_LOAD:   if (init_pulse) next_state = S_INIT_SETTLE;
      S_INIT_SETTLE: if (settle_done) next_state = S_IDLE;
      S_IDLE: begin
        if (REQ_VALID) begin
          if (!lane_ok)                                next_state = S_RESP;
          else if (REQ_OP == OP_LOAD)                  next_state = S_LOAD;
          else if (acc_steps == '0 || acc_at_limit)    next_state = S_RESP;
          else                                         next_state = S_DIR;
        end
      end
      S_DIR:   next_state = S_MOVE;
      S_MOVE:  next_state = S_SETTLE;
      S_SETTLE: begin
        if (settle_done) begin
          if (oor_hit || steps_q == TAP_W'(1) || step_at_limit) next_state = S_RESP;
          else                                                   next_state = S_MOVE;
        end
      end
      S_LOAD:    next_state = S_LSETTLE;
      S_LSETTLE: if (settle_done) next_state = S_RESP;
      S_RESP:    next_state = S_IDLE;
      default:   next_state = S_INIT_LOAD;
    endcase
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      init_pulse <= 1'b0;
      lane_q     <= '0;
      dir_q      <= 1'b0;
      steps_q    <= '0;
      cnt_q      <= '0;
      clip_q     <= 1'b0;
      oor_q      <= 1'b0;
      bad_q      <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) taps[i] <= LOAD_T;
    end else begin
      init_pulse <= (state == S_INIT_LOAD) && !init_pulse;

      case (state)
        S_INIT_LOAD, S_MOVE, S_LOAD:       cnt_q <= SETTLE_LAST;
        S_INIT_SETTLE, S_SETTLE, S_LSETTLE: if (!settle_done) cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase

      if (state == S_IDLE && REQ_VALID) begin
        lane_q  <= REQ_LANE;
        dir_q   <= acc_dir;
        steps_q <= acc_steps;
        bad_q   <= !lane_ok;
        oor_q   <= 1'b0;
        clip_q  <= acc_clip || (acc_steps != '0 && acc_at_limit);
      end

      if (state == S_SETTLE && settle_done) begin
        if (oor_hit) begin
          oor_q <= 1'b1;
        end else begin
          steps_q <= steps_q - 1'b1;
          for (int i = 0; i < NUM_LANES; i++)
            if (lane_oh[i]) taps[i] <= step_tap;
          // Running into the limit with steps still pending is a clip.
          if (steps_q != TAP_W'(1) && step_at_limit) clip_q <= 1'b1;
        end
      end

      if (state == S_LOAD) begin
        for (int i = 0; i < NUM_LANES; i++)
          if (lane_oh[i]) taps[i] <= LOAD_T;
      end
    end
  end

  always_comb begin
    REQ_READY  = (state == S_IDLE);
    BUSY       = (state != S_IDLE);
    RSP_VALID  = (state == S_RESP);
    RSP_STATUS = 2'b00;
    RSP_TAPS   = '0;
    if (state == S_RESP) begin
      RSP_STATUS = bad_q ? 2'b11 : (oor_q ? 2'b10 : (clip_q ? 2'b01 : 2'b00));
      RSP_TAPS   = sel_tap;
    end
    DELAY_LINE_MOVE      = (state == S_MOVE) ? lane_oh : '0;
    DELAY_LINE_DIRECTION = ((state == S_DIR || state == S_MOVE || state == S_SETTLE) && dir_q)
                           ? lane_oh : '0;
    DELAY_LINE_LOAD      = ((state == S_LOAD) ? lane_oh : '0) | {NUM_LANES{init_pulse}};
    TAP_COUNT = '0;
    for (int i = 0; i < NUM_LANES; i++) TAP_COUNT[i*TAP_W +: TAP_W] = taps[i];
  end

endmodule

// File: tb/tb_ddr_ca_lane_delay_ctrl.sv
// Bench for ddr_ca_lane_delay_ctrl. Lane index and tap widths are widened so
// an out-of-range lane and a set target above MAX_TAP can be presented.
module tb_ddr_ca_lane_delay_ctrl;
  localparam int NL   = 8;
  localparam int LW   = 4;
  localparam int TW   = 9;
  localparam int MAXT = 255;
  localparam int LDT  = 1;
  localparam int S    = 4;

  logic FAB_CLK = 1'b0;
  logic ARST_N  = 1'b0;
  logic REQ_VALID, REQ_READY;
  logic [LW-1:0] REQ_LANE;
  logic [1:0] REQ_OP;
  logic [TW-1:0] REQ_STEPS;
  logic RSP_VALID;
  logic [1:0] RSP_STATUS;
  logic [TW-1:0] RSP_TAPS;
  logic BUSY;
  logic [NL-1:0] mv, dirn, ld, oor;
  logic [NL*TW-1:0] tc;

  int total = 0;
  int bad   = 0;
  int mtap [NL];

  ddr_ca_lane_delay_ctrl #(
    .NUM_LANES(NL), .LANE_W(LW), .TAP_W(TW), .MAX_TAP(MAXT),
    .LOAD_TAP(LDT), .SETTLE_CYCLES(S)
  ) dut (
    .FAB_CLK(FAB_CLK), .ARST_N(ARST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_LANE(REQ_LANE), .REQ_OP(REQ_OP), .REQ_STEPS(REQ_STEPS),
    .RSP_VALID(RSP_VALID), .RSP_STATUS(RSP_STATUS), .RSP_TAPS(RSP_TAPS),
    .BUSY(BUSY),
    .DELAY_LINE_MOVE(mv), .DELAY_LINE_DIRECTION(dirn), .DELAY_LINE_LOAD(ld),
    .DELAY_LINE_OUT_OF_RANGE(oor), .TAP_COUNT(tc)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_taps(input string tag);
    for (int i = 0; i < NL; i++) chk(tag, tc[i*TW +: TW], mtap[i]);
  endtask

  task automatic run_init();
    int loads  = 0;
    int load_c = -1;
    int idle_c = -1;
    for (int i = 0; i < NL; i++) mtap[i] = LDT;
    ARST_N = 1'b0;
    repeat (2) @(negedge FAB_CLK);
    chk("rst_busy", BUSY, 1);
    chk("rst_ready", REQ_READY, 0);
    chk("rst_pulses", {mv, ld, dirn}, 0);
    chk("rst_rsp", {RSP_VALID, RSP_STATUS, RSP_TAPS}, 0);
    check_taps("rst_taps");
    ARST_N = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge FAB_CLK);
      if (ld === {NL{1'b1}}) begin
        loads++;
        if (load_c < 0) load_c = c;
      end
      if (BUSY === 1'b0 && idle_c < 0) idle_c = c;
    end
    chk("init_load_count", loads, 1);
    chk("init_load_cycle", load_c, 1);
    chk("init_idle_cycle", idle_c, 6);
    check_taps("init_taps");
  endtask

  // Expected outcome is derived from the tap range arithmetic, not from the FSM.
  task automatic do_req(input int lane, input int op, input int steps, input int oor_step);
    int tap, dir, want, room, m, done, st, lat, clip_s, tgt, new_tap;
    int moves = 0, loads = 0, rsp_c = -1, stray = 0, ready_bad = 0;
    logic [1:0] got_st;
    logic [TW-1:0] got_taps;
    logic [NL-1:0] oh;
    oh = '0;
    if (lane < NL) oh[lane] = 1'b1;
    got_st = 2'b00;
    got_taps = '0;
    tap = (lane < NL) ? mtap[lane] : 0;
    dir = 1; m = 0; st = 0; new_tap = tap; lat = 1;
    if (lane >= NL) begin
      st = 3;
    end else if (op == 2) begin
      new_tap = LDT;
      lat = 2 + S;
    end else begin
      clip_s = 0;
      if (op == 0) begin dir = 1; want = steps; room = MAXT - tap; end
      else if (op == 1) begin dir = 0; want = steps; room = tap; end
      else begin
        tgt    = (steps > MAXT) ? MAXT : steps;
        clip_s = (steps > MAXT) ? 1 : 0;
        dir    = (tgt > tap) ? 1 : 0;
        want   = dir ? tgt - tap : tap - tgt;
        room   = want;
      end
      m    = (want < room) ? want : room;
      st   = (want > room || clip_s != 0) ? 1 : 0;
      done = m;
      if (oor_step > 0 && oor_step <= m) begin
        m = oor_step;
        done = m - 1;
        st = 2;
      end
      new_tap = dir ? tap + done : tap - done;
      lat = (m == 0) ? 1 : 2 + m * (1 + S);
    end

    @(negedge FAB_CLK);
    chk("ready_before", REQ_READY, 1);
    REQ_VALID = 1'b1;
    REQ_LANE  = LW'(lane);
    REQ_OP    = 2'(op);
    REQ_STEPS = TW'(steps);
    @(posedge FAB_CLK);
    #1 REQ_VALID = 1'b0;
    for (int c = 1; c <= lat + 10 && rsp_c < 0; c++) begin
      @(negedge FAB_CLK);
      if (REQ_READY !== 1'b0) ready_bad++;
      if ((mv & ~oh) != '0 || (dirn & ~oh) != '0 || (ld & ~oh) != '0) stray++;
      if (lane < NL) begin
        if (mv[lane] === 1'b1) begin
          chk("move_time", c, 2 + moves * (1 + S));
          chk("move_dir", dirn[lane], dir);
          moves++;
          if (moves == oor_step) oor[lane] = 1'b1;
        end
        if (ld[lane] === 1'b1) begin
          loads++;
          chk("load_time", c, 1);
        end
      end
      if (RSP_VALID === 1'b1) begin
        rsp_c    = c;
        got_st   = RSP_STATUS;
        got_taps = RSP_TAPS;
      end
    end
    oor = '0;
    chk("rsp_latency", rsp_c, lat);
    chk("rsp_status", got_st, st);
    if (lane < NL) chk("rsp_taps", got_taps, new_tap);
    chk("move_count", moves, m);
    chk("load_count", loads, (op == 2 && lane < NL) ? 1 : 0);
    chk("stray_lane_bits", stray, 0);
    chk("ready_while_busy", ready_bad, 0);
    if (lane < NL) mtap[lane] = new_tap;
    @(negedge FAB_CLK);
    chk("rsp_one_cycle", RSP_VALID, 0);
    check_taps("tap_count");
  endtask

  initial begin
    int moves;
    REQ_VALID = 1'b0;
    REQ_LANE  = '0;
    REQ_OP    = 2'b00;
    REQ_STEPS = '0;
    oor       = '0;

    run_init();
    do_req(2, 0, 3, 0);      // inc 3: RSP at t+17, taps 4
    do_req(0, 3, 300, 0);    // set above MAX_TAP: 254 moves, clip
    do_req(0, 0, 1, 0);      // inc at MAX_TAP: immediate clip
    do_req(5, 3, 10, 0);     // raise lane 5 to 10
    do_req(5, 1, 4, 2);      // out-of-range during second settle
    do_req(9, 0, 3, 0);      // bad lane
    do_req(4, 0, 0, 0);      // zero-step increment
    do_req(1, 2, 0, 0);      // lane load
    do_req(6, 1, 3, 0);      // decrement runs into 0 after one step
    do_req(0, 3, 255, 0);    // set to current tap: zero steps

    for (int n = 0; n < 20; n++) begin
      int lane, op, steps, os;
      lane  = $urandom_range(0, 9);
      op    = $urandom_range(0, 3);
      steps = (op == 3) ? $urandom_range(0, 40) : $urandom_range(0, 6);
      os    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      do_req(lane, op, steps, os);
    end

    // Reset in the middle of a 10-step request.
    @(negedge FAB_CLK);
    REQ_VALID = 1'b1;
    REQ_LANE  = LW'(3);
    REQ_OP    = 2'b00;
    REQ_STEPS = TW'(10);
    @(posedge FAB_CLK);
    #1 REQ_VALID = 1'b0;
    moves = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge FAB_CLK);
      if (mv[3] === 1'b1) moves++;
      else if (moves == 2) break;
    end
    chk("mid_moves_seen", moves, 2);
    chk("mid_dir_before", dirn[3], 1);
    ARST_N = 1'b0;
    #1;
    chk("mid_move_drop", mv, 0);
    chk("mid_dir_drop", dirn, 0);
    chk("mid_no_rsp", RSP_VALID, 0);
    chk("mid_busy", BUSY, 1);
    run_init();
    do_req(3, 0, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
